uart_rx_buffer: RTL and testbench

- Downstream stage of the UART receiver. Consumes the receiver's frame outputs (data, level-type valid, parity error), which are produced in the baud_tick domain.
- Brings the valid into the system clock domain and detects each new frame once.
- Stores data plus parity flag in a first-word-fall-through FIFO and presents frames to the system over a valid/ready handshake.
- Sticky overflow flag and occupancy count for software/status logic.

---
 rtl/uart_rx_buffer.sv | 124 ++++++++++++
 tb/tb_uart_rx_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART frame buffer: syncs the receiver's level valid, pushes each new frame once into a FWFT FIFO.
// Latency: 3 clk from rx_valid first sampled to m_valid; frames arriving while full are dropped and flagged.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr;
  logic             rd;

  assign full   = (count == CNT_W'(DEPTH));
  assign rd_vld = (count != '0);
  assign rd     = rd_vld & rd_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_rdy = ~full | rd;
  assign wr     = wr_vld & wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module uart_rx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_parity_err,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_parity_err,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  input  logic                      clr_overflow
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic s1, s2, s3;
  logic push_vld;
  logic push_rdy;

  // Sync stages come out of reset high so a valid already asserted is not seen as a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx_valid;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push_vld = s2 & ~s3;

  fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat ({rx_parity_err, rx_data}),
    .rd_vld (m_valid),
    .rd_rdy (m_ready),
    .rd_dat ({m_parity_err, m_data}),
    .count  (count)
  );

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (push_vld & ~push_rdy)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer (DEPTH=16): latency, ordering, overflow, full push+pop, wrap, reset.
module tb_uart_rx_buffer;
  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic [7:0] m_data;
  logic       m_parity_err;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .m_data        (m_data),
    .m_parity_err  (m_parity_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e, input int hold);
    rx_data       = d;
    rx_parity_err = e;
    rx_valid      = 1'b1;
    tick(hold);
    rx_valid = 1'b0;
    tick(3);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic e);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_data"}, 32'(m_data), 32'(d));
    check({tag, "_perr"}, 32'(m_parity_err), 32'(e));
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_q[$];
    logic [8:0] head;
    int         drain;

    rst           = 1'b1;
    rx_data       = 8'h00;
    rx_valid      = 1'b0;
    rx_parity_err = 1'b0;
    m_ready       = 1'b0;
    clr_overflow  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick(2);
    check("idle_no_push", 32'(count), 32'd0);

    // Single frame: m_valid appears after the third sampling edge.
    rx_data       = 8'hA5;
    rx_parity_err = 1'b0;
    rx_valid      = 1'b1;
    tick(2);
    check("lat_e1_m_valid", 32'(m_valid), 32'd0);
    tick(1);
    check("lat_e2_m_valid", 32'(m_valid), 32'd1);
    check("single_data", 32'(m_data), 32'hA5);
    check("single_count", 32'(count), 32'd1);
    tick(5);
    rx_valid = 1'b0;
    tick(3);
    check("single_no_repush", 32'(count), 32'd1);
    pop_check("single_pop", 8'hA5, 1'b0);
    check("single_empty", 32'(empty), 32'd1);

    // Parity flag travels with its data.
    send_frame(8'h3C, 1'b1, 4);
    send_frame(8'h81, 1'b0, 4);
    check("par_count2", 32'(count), 32'd2);
    pop_check("par_pop0", 8'h3C, 1'b1);
    check("par_count1", 32'(count), 32'd1);
    pop_check("par_pop1", 8'h81, 1'b0);
    check("par_count0", 32'(count), 32'd0);
    check("par_empty", 32'(empty), 32'd1);

    // Fill past capacity: the last two frames are dropped.
    for (int i = 0; i < 18; i++) send_frame(8'(i), 1'b0, 4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop_check("fill_pop", 8'(i), 1'b0);
    check("fill_drained", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push coincides with pop, nothing dropped.
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b0, 4);
    check("fp_full", 32'(full), 32'd1);
    check("fp_head", 32'(m_data), 32'h40);
    rx_data       = 8'h99;
    rx_parity_err = 1'b1;
    rx_valid      = 1'b1;
    tick(2);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("fp_count", 32'(count), 32'd16);
    check("fp_no_overflow", 32'(overflow), 32'd0);
    tick(2);
    rx_valid = 1'b0;
    tick(3);
    for (int i = 1; i < 16; i++) pop_check("fp_pop", 8'h40 + 8'(i), 1'b0);
    pop_check("fp_pop_last", 8'h99, 1'b1);
    check("fp_empty", 32'(empty), 32'd1);

    // Wrap-around: 40 frames, consumer ready one cycle in three.
    for (int cyc = 0; cyc < 280; cyc++) begin
      if (cyc % 7 == 0) begin
        rx_data       = 8'(cyc / 7 * 37 + 11);
        rx_parity_err = 1'((cyc / 7) % 2);
        exp_q.push_back({rx_parity_err, rx_data});
      end
      rx_valid = (cyc % 7) < 4;
      m_ready  = (cyc % 3 == 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          check("wrap_data", 32'({m_parity_err, m_data}), 32'(head));
        end else begin
          check("wrap_unexpected_pop", 32'd1, 32'd0);
        end
      end
      check("wrap_count_le_depth", 32'(count <= 5'd16), 32'd1);
      tick(1);
    end
    rx_valid = 1'b0;
    drain    = 0;
    while (exp_q.size() > 0 && drain < 60) begin
      m_ready = 1'b1;
      if (m_valid) begin
        head = exp_q.pop_front();
        check("wrap_drain", 32'({m_parity_err, m_data}), 32'(head));
      end
      tick(1);
      drain++;
    end
    m_ready = 1'b0;
    check("wrap_all_popped", 32'(exp_q.size()), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_no_overflow", 32'(overflow), 32'd0);

    // Reset mid-operation with a frame pending on rx_valid.
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 4);
    check("mid_count5", 32'(count), 32'd5);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    rx_valid = 1'b0;
    tick(3);
    check("mid_pending_dropped", 32'(count), 32'd0);
    send_frame(8'h5A, 1'b0, 4);
    check("post_rst_count", 32'(count), 32'd1);
    pop_check("post_rst_pop", 8'h5A, 1'b0);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
